// File: rtl/tbtt_scheduler.sv
// Beacon timing: aligns TBTTs to multiples of the beacon interval on the TSF, then issues
// a pre-TBTT warning, a TBTT pulse and a held beacon request to the TX path.
module tbtt_scheduler #(
  parameter int TIMER_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [15:0]            beacon_interval_tu,
  input  logic [15:0]            tbtt_lead_us,
  input  logic [TIMER_WIDTH-1:0] tsf_runtime_val,
  input  logic                   tsf_resync,
  input  logic                   beacon_ack,
  output logic                   tbtt_pre_pulse,
  output logic                   tbtt_pulse,
  output logic                   beacon_req,
  output logic [TIMER_WIDTH-1:0] next_tbtt,
  output logic [31:0]            tbtt_count,
  output logic [15:0]            missed_count,
  output logic                   aligning,
  output logic                   cfg_err
);

  localparam int IW = 26;  // interval in us: 16-bit TU count times 1024

  typedef enum logic [1:0] {IDLE, ALIGN, WAIT} state_t;

  state_t                 state;
  logic [TIMER_WIDTH-1:0] snapshot;
  logic [TIMER_WIDTH-1:0] div_sh;
  logic [IW-1:0]          iv_us;
  logic [IW-1:0]          lead_eff;
  logic [IW-1:0]          rem;
  logic [6:0]             bit_cnt;
  logic                   pre_sent;

  logic [IW-1:0]          iv_new;
  logic [IW-1:0]          iv_new_m1;
  logic [IW-1:0]          lead_new;
  logic [TIMER_WIDTH-1:0] iv_ext;
  logic [TIMER_WIDTH-1:0] lead_ext;
  logic [IW:0]            trial;
  logic [IW-1:0]          rem_step;
  logic                   tbtt_due;
  logic                   pre_due;
  logic                   jump_fwd;
  logic                   jump_bwd;
  logic                   start_align;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    iv_new      = {beacon_interval_tu, 10'd0};
    iv_new_m1   = iv_new - 26'd1;
    lead_new    = ({10'd0, tbtt_lead_us} > iv_new_m1) ? iv_new_m1 : {10'd0, tbtt_lead_us};
    iv_ext      = {{(TIMER_WIDTH-IW){1'b0}}, iv_us};
    lead_ext    = {{(TIMER_WIDTH-IW){1'b0}}, lead_eff};

    // One restoring-division step: bring in the next dividend bit, subtract if it fits.
    trial       = {rem, div_sh[TIMER_WIDTH-1]};
    rem_step    = (trial >= {1'b0, iv_us}) ? IW'(trial - {1'b0, iv_us}) : trial[IW-1:0];

    tbtt_due    = tsf_runtime_val >= next_tbtt;
    pre_due     = (lead_eff != '0) && !pre_sent && (tsf_runtime_val >= next_tbtt - lead_ext);
    jump_fwd    = tsf_runtime_val >= next_tbtt + iv_ext;
    jump_bwd    = (tsf_runtime_val + iv_ext) < next_tbtt;

    start_align = 1'b0;
    case (state)
      IDLE:    start_align = (beacon_interval_tu != 16'd0);
      ALIGN:   start_align = tsf_resync;
      WAIT:    start_align = tsf_resync || jump_fwd || jump_bwd;
      default: start_align = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      snapshot       <= '0;
      div_sh         <= '0;
      iv_us          <= '0;
      lead_eff       <= '0;
      rem            <= '0;
      bit_cnt        <= '0;
      pre_sent       <= 1'b0;
      tbtt_pre_pulse <= 1'b0;
      tbtt_pulse     <= 1'b0;
      beacon_req     <= 1'b0;
      next_tbtt      <= '0;
      tbtt_count     <= '0;
      missed_count   <= '0;
      aligning       <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      tbtt_pre_pulse <= 1'b0;
      tbtt_pulse     <= 1'b0;

      if (!enable) begin
        // Timing results and counters hold for inspection; counters clear on re-enable.
        state      <= IDLE;
        beacon_req <= 1'b0;
        pre_sent   <= 1'b0;
        aligning   <= 1'b0;
        cfg_err    <= 1'b0;
      end else if (start_align) begin
        state    <= ALIGN;
        aligning <= 1'b1;
        snapshot <= tsf_runtime_val;
        div_sh   <= tsf_runtime_val;
        rem      <= '0;
        bit_cnt  <= '0;
        pre_sent <= 1'b0;
        // A zero interval on a re-align keeps the last good configuration.
        if (beacon_interval_tu == 16'd0) begin
          cfg_err <= 1'b1;
        end else begin
          iv_us    <= iv_new;
          lead_eff <= lead_new;
        end
        if (state == IDLE) begin
          tbtt_count   <= '0;
          missed_count <= '0;
        end
        if (beacon_ack) beacon_req <= 1'b0;
      end else begin
        case (state)
          IDLE: cfg_err <= 1'b1;
          ALIGN: begin
            if (beacon_ack) beacon_req <= 1'b0;
            if (bit_cnt == 7'd64) begin
              next_tbtt <= snapshot - {{(TIMER_WIDTH-IW){1'b0}}, rem} + iv_ext;
              state     <= WAIT;
              aligning  <= 1'b0;
            end else begin
              rem     <= rem_step;
              div_sh  <= div_sh << 1;
              bit_cnt <= bit_cnt + 7'd1;
            end
          end
          WAIT: begin
            if (tbtt_due) begin
              tbtt_pulse <= 1'b1;
              next_tbtt  <= next_tbtt + iv_ext;
              tbtt_count <= tbtt_count + 32'd1;
              pre_sent   <= 1'b0;
              beacon_req <= 1'b1;
              // An ack landing with the new TBTT means the previous beacon did go out.
              if (beacon_req && !beacon_ack && missed_count != 16'hFFFF)
                missed_count <= missed_count + 16'd1;
            end else begin
              if (beacon_ack) beacon_req <= 1'b0;
              if (pre_due) begin
                tbtt_pre_pulse <= 1'b1;
                pre_sent       <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tbtt_scheduler.sv
// Bench for tbtt_scheduler: directed vector table, hand-written corner sequences and
// randomized traffic checked against a behavioural model built on plain modulo arithmetic.
module tb_tbtt_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] tu;
  logic [15:0] lead;
  logic [63:0] tsf;
  logic        tsf_resync;
  logic        beacon_ack;
  logic        tbtt_pre_pulse;
  logic        tbtt_pulse;
  logic        beacon_req;
  logic [63:0] next_tbtt;
  logic [31:0] tbtt_count;
  logic [15:0] missed_count;
  logic        aligning;
  logic        cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tbtt_scheduler #(.TIMER_WIDTH(64)) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .beacon_interval_tu (tu),
    .tbtt_lead_us       (lead),
    .tsf_runtime_val    (tsf),
    .tsf_resync         (tsf_resync),
    .beacon_ack         (beacon_ack),
    .tbtt_pre_pulse     (tbtt_pre_pulse),
    .tbtt_pulse         (tbtt_pulse),
    .beacon_req         (beacon_req),
    .next_tbtt          (next_tbtt),
    .tbtt_count         (tbtt_count),
    .missed_count       (missed_count),
    .aligning           (aligning),
    .cfg_err            (cfg_err)
  );

  typedef struct {
    logic        en;
    logic [15:0] tu;
    logic [15:0] lead;
    logic [63:0] tsf;
    logic        rs;
    logic        ack;
    int          cyc;
    logic        pre;
    logic        tp;
    logic        req;
    logic [63:0] nxt;
    logic [31:0] cnt;
    logic [15:0] miss;
    logic        al;
    logic        cfg;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [15:0] t, input logic [15:0] l,
                       input logic [63:0] ts, input logic rs, input logic ak);
    enable     = en;
    tu         = t;
    lead       = l;
    tsf        = ts;
    tsf_resync = rs;
    beacon_ack = ak;
  endtask

  task automatic check_outs(input string tag, input logic pre, input logic tp, input logic req,
                            input logic [63:0] nxt, input logic [31:0] cnt, input logic [15:0] miss,
                            input logic al, input logic cfg);
    check({tag, "_pre"},     64'(tbtt_pre_pulse), 64'(pre));
    check({tag, "_tbtt"},    64'(tbtt_pulse),     64'(tp));
    check({tag, "_req"},     64'(beacon_req),     64'(req));
    check({tag, "_next"},    next_tbtt,           nxt);
    check({tag, "_count"},   64'(tbtt_count),     64'(cnt));
    check({tag, "_missed"},  64'(missed_count),   64'(miss));
    check({tag, "_align"},   64'(aligning),       64'(al));
    check({tag, "_cfg_err"}, 64'(cfg_err),        64'(cfg));
  endtask

  function automatic vec_t mk(input logic en, input logic [15:0] t, input logic [15:0] l,
                              input logic [63:0] ts, input logic rs, input logic ak, input int cyc,
                              input logic pre, input logic tp, input logic req, input logic [63:0] nxt,
                              input logic [31:0] cnt, input logic [15:0] miss, input logic al,
                              input logic cfg);
    vec_t v;
    v.en = en; v.tu = t; v.lead = l; v.tsf = ts; v.rs = rs; v.ack = ak; v.cyc = cyc;
    v.pre = pre; v.tp = tp; v.req = req; v.nxt = nxt; v.cnt = cnt; v.miss = miss;
    v.al = al; v.cfg = cfg;
    return v;
  endfunction

  // Behavioural model: alignment is a 65-cycle countdown, the target is computed with '%'.
  logic        m_on;
  int          m_left;
  logic [63:0] m_iv;
  logic [63:0] m_lead;
  logic [63:0] m_pend;
  logic        m_pre_sent;
  logic        e_pre, e_tp, e_req, e_al, e_cfg;
  logic [63:0] e_next;
  logic [31:0] e_cnt;
  logic [15:0] e_miss;

  task automatic model_reset();
    m_on = 1'b0; m_left = 0; m_iv = '0; m_lead = '0; m_pend = '0; m_pre_sent = 1'b0;
    e_pre = 1'b0; e_tp = 1'b0; e_req = 1'b0; e_al = 1'b0; e_cfg = 1'b0;
    e_next = '0; e_cnt = '0; e_miss = '0;
  endtask

  task automatic model_align();
    m_iv       = 64'(tu) * 64'd1024;
    m_lead     = (64'(lead) > m_iv - 64'd1) ? m_iv - 64'd1 : 64'(lead);
    m_pend     = tsf - (tsf % m_iv) + m_iv;
    m_left     = 65;
    e_al       = 1'b1;
    m_pre_sent = 1'b0;
  endtask

  task automatic model_edge();
    e_pre = 1'b0;
    e_tp  = 1'b0;
    if (!enable) begin
      m_on = 1'b0; m_left = 0; e_al = 1'b0; e_req = 1'b0; m_pre_sent = 1'b0; e_cfg = 1'b0;
    end else if (!m_on) begin
      if (tu == 16'd0) e_cfg = 1'b1;
      else begin
        m_on = 1'b1; e_cnt = '0; e_miss = '0;
        model_align();
      end
    end else if (m_left > 0) begin
      if (beacon_ack) e_req = 1'b0;
      if (tsf_resync) model_align();
      else begin
        m_left--;
        if (m_left == 0) begin
          e_next = m_pend;
          e_al   = 1'b0;
        end
      end
    end else if (tsf_resync || tsf >= e_next + m_iv || tsf + m_iv < e_next) begin
      if (beacon_ack) e_req = 1'b0;
      model_align();
    end else if (tsf >= e_next) begin
      e_tp = 1'b1;
      e_next = e_next + m_iv;
      e_cnt++;
      m_pre_sent = 1'b0;
      if (e_req && !beacon_ack && e_miss != 16'hFFFF) e_miss++;
      e_req = 1'b1;
    end else begin
      if (beacon_ack) e_req = 1'b0;
      if (m_lead != 0 && !m_pre_sent && tsf >= e_next - m_lead) begin
        e_pre = 1'b1;
        m_pre_sent = 1'b1;
      end
    end
  endtask

  initial begin
    logic        r_en;
    logic [15:0] r_tu;
    logic [15:0] r_lead;
    logic [63:0] r_tsf;
    logic [63:0] r_back;

    // Reset state
    rst = 1'b1;
    drive(1'b0, 16'd0, 16'd0, 64'd0, 1'b0, 1'b0);
    tick(3);
    check_outs("reset", 0, 0, 0, 64'd0, 0, 0, 0, 0);
    rst = 1'b0;

    // en tu lead tsf rs ack cyc | pre tp req next cnt miss al cfg
    vt.push_back(mk(1, 0,   0,    0,      0, 0, 1,  0, 0, 0, 0,      0, 0, 0, 1));
    vt.push_back(mk(1, 0,   0,    0,      0, 0, 3,  0, 0, 0, 0,      0, 0, 0, 1));
    vt.push_back(mk(0, 0,   0,    0,      0, 0, 1,  0, 0, 0, 0,      0, 0, 0, 0));
    vt.push_back(mk(1, 100, 2000, 250000, 0, 0, 1,  0, 0, 0, 0,      0, 0, 1, 0));
    vt.push_back(mk(1, 100, 2000, 250000, 0, 0, 64, 0, 0, 0, 0,      0, 0, 1, 0));
    vt.push_back(mk(1, 100, 2000, 250000, 0, 0, 1,  0, 0, 0, 307200, 0, 0, 0, 0));
    vt.push_back(mk(1, 100, 2000, 305199, 0, 0, 1,  0, 0, 0, 307200, 0, 0, 0, 0));
    vt.push_back(mk(1, 100, 2000, 305200, 0, 0, 1,  1, 0, 0, 307200, 0, 0, 0, 0));
    vt.push_back(mk(1, 100, 2000, 305201, 0, 0, 1,  0, 0, 0, 307200, 0, 0, 0, 0));
    vt.push_back(mk(1, 100, 2000, 307199, 0, 0, 1,  0, 0, 0, 307200, 0, 0, 0, 0));
    vt.push_back(mk(1, 100, 2000, 307200, 0, 0, 1,  0, 1, 1, 409600, 1, 0, 0, 0));
    vt.push_back(mk(1, 100, 2000, 307201, 0, 0, 1,  0, 0, 1, 409600, 1, 0, 0, 0));
    vt.push_back(mk(1, 100, 2000, 409600, 0, 0, 1,  0, 1, 1, 512000, 2, 1, 0, 0));
    vt.push_back(mk(1, 100, 2000, 512000, 0, 1, 1,  0, 1, 1, 614400, 3, 1, 0, 0));
    vt.push_back(mk(1, 100, 2000, 512001, 0, 1, 1,  0, 0, 0, 614400, 3, 1, 0, 0));
    vt.push_back(mk(1, 100, 2000, 512002, 0, 0, 2,  0, 0, 0, 614400, 3, 1, 0, 0));

    foreach (vt[i]) begin
      drive(vt[i].en, vt[i].tu, vt[i].lead, vt[i].tsf, vt[i].rs, vt[i].ack);
      tick(vt[i].cyc);
      check_outs($sformatf("vec%0d", i), vt[i].pre, vt[i].tp, vt[i].req, vt[i].nxt,
                 vt[i].cnt, vt[i].miss, vt[i].al, vt[i].cfg);
    end

    // Forward jump re-aligns without a TBTT pulse; resync at tsf=0 restarts from the first interval
    drive(0, 16'd100, 16'd2000, 64'd250000, 0, 0); tick(1);
    drive(1, 16'd100, 16'd2000, 64'd250000, 0, 0); tick(66);
    check_outs("jmp_base", 0, 0, 0, 64'd307200, 0, 0, 0, 0);
    tsf = 64'd1000000; tick(1);
    check_outs("jmp_fwd", 0, 0, 0, 64'd307200, 0, 0, 1, 0);
    tick(65);
    check_outs("jmp_done", 0, 0, 0, 64'd1024000, 0, 0, 0, 0);
    drive(1, 16'd100, 16'd2000, 64'd0, 1, 0); tick(1);
    tsf_resync = 1'b0;
    check_outs("resync", 0, 0, 0, 64'd1024000, 0, 0, 1, 0);
    tick(65);
    check_outs("resync_done", 0, 0, 0, 64'd102400, 0, 0, 0, 0);

    // Lead clamped to iv-1 = 1023: threshold is 4096-1023 = 3073
    drive(0, 16'd1, 16'hFFFF, 64'd3072, 0, 0); tick(1);
    drive(1, 16'd1, 16'hFFFF, 64'd3072, 0, 0); tick(66);
    check_outs("clamp_base", 0, 0, 0, 64'd4096, 0, 0, 0, 0);
    tick(1);
    check_outs("clamp_below", 0, 0, 0, 64'd4096, 0, 0, 0, 0);
    tsf = 64'd3073; tick(1);
    check_outs("clamp_pre", 1, 0, 0, 64'd4096, 0, 0, 0, 0);
    tsf = 64'd3074; tick(1);
    check_outs("clamp_once", 0, 0, 0, 64'd4096, 0, 0, 0, 0);

    // Disable mid-ALIGN and mid-WAIT with a pending request
    drive(0, 16'd100, 16'd2000, 64'd250000, 0, 0); tick(1);
    drive(1, 16'd100, 16'd2000, 64'd250000, 0, 0); tick(10);
    check_outs("dis_align_pre", 0, 0, 0, 64'd4096, 0, 0, 1, 0);
    enable = 1'b0; tick(1);
    check_outs("dis_align", 0, 0, 0, 64'd4096, 0, 0, 0, 0);
    enable = 1'b1; tick(66);
    tsf = 64'd307200; tick(1);
    check_outs("dis_wait_pre", 0, 1, 1, 64'd409600, 1, 0, 0, 0);
    enable = 1'b0; tick(1);
    check_outs("dis_wait", 0, 0, 0, 64'd409600, 1, 0, 0, 0);

    // Reset wins over an active enable
    drive(1, 16'd100, 16'd2000, 64'd250000, 0, 0);
    rst = 1'b1; tick(1);
    check_outs("rst_prio", 0, 0, 0, 64'd0, 0, 0, 0, 0);

    // Randomized traffic against the model
    model_reset();
    rst = 1'b0;
    r_en = 1'b1; r_tu = 16'd1; r_lead = 16'd300; r_tsf = 64'd5000;
    for (int c = 0; c < 12000; c++) begin
      if (r_en && $urandom_range(0, 299) == 0) r_en = 1'b0;
      else if (!r_en && $urandom_range(0, 3) == 0) r_en = 1'b1;
      if ($urandom_range(0, 59) == 0) r_tu = 16'($urandom_range(1, 3));
      if ($urandom_range(0, 59) == 0) r_lead = 16'($urandom_range(0, 4000));
      case ($urandom_range(0, 199))
        0, 1:    r_tsf = r_tsf + 64'($urandom_range(4000, 12000));
        2, 3:    begin
                   r_back = 64'($urandom_range(4000, 12000));
                   if (r_tsf > r_back) r_tsf = r_tsf - r_back;
                 end
        4, 5, 6, 7, 8: r_tsf = r_tsf + 64'($urandom_range(100, 600));
        default: r_tsf = r_tsf + 64'($urandom_range(0, 8));
      endcase
      drive(r_en, r_tu, r_lead, r_tsf, 1'b0, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 149) == 0) begin
        tsf_resync = 1'b1;
        if ($urandom_range(0, 1) == 0) begin
          r_tsf = 64'd0;
          tsf   = r_tsf;
        end
      end
      model_edge();
      tick(1);
      check_outs("rnd", e_pre, e_tp, e_req, e_next, e_cnt, e_miss, e_al, e_cfg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
